param_combination_lock: RTL and testbench

PARAM_COMBINATION_LOCK -- requirements
Module: param_combination_lock

---
 rtl/param_combination_lock.sv | 203 ++++++++++++++++++++
 tb/tb_param_combination_lock.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/param_combination_lock.sv
// param_combination_lock
//   Digit-by-digit combination lock with a programmable code, wrong-entry
//   lockout and a single-digit seven-segment status display.
//
// Ports
//   clk                  : clock, all state updates on the rising edge
//   reset                : synchronous, active-high
//   x[DIGIT_W-1:0]       : digit value, sampled when enter=1
//   enter                : one digit entry per cycle it is high
//   lock                 : close the door (OPEN) or abort programming (PROGRAM)
//   prog                 : request code-change mode while the door is open
//   door_open            : registered, high in OPEN and PROGRAM
//   locked_out           : registered, high in LOCKOUT
//   seven_segment_data   : active-low segments, bit7 = decimal point (always off)
//   seven_segment_enable : constant 4'b1110 (rightmost digit only)
module param_combination_lock #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = {4'd2, 4'd3, 4'd4, 4'd6},
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] x,
    input  logic               enter,
    input  logic               lock,
    input  logic               prog,
    output logic               door_open,
    output logic               locked_out,
    output logic [7:0]         seven_segment_data,
    output logic [3:0]         seven_segment_enable
);

    localparam int CODE_W = DIGIT_W * CODE_LEN;
    // CODE_LEN tops out at 9, so four bits hold any digit index
    localparam int IDX_W  = 4;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        PROGRAM = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [TMR_W-1:0]    timer;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   shadow;

    logic [DIGIT_W-1:0]  cur_digit;
    logic [FAIL_W-1:0]   fail_next;
    logic [CODE_W-1:0]   shadow_next;

    // Digit 0 lives in the most significant slice of a code word
    function automatic logic [DIGIT_W-1:0] get_digit(input logic [CODE_W-1:0] c,
                                                     input logic [IDX_W-1:0]  i);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int k = 0; k < CODE_LEN; k++)
            if (i == IDX_W'(k))
                d = c[(CODE_LEN-1-k)*DIGIT_W +: DIGIT_W];
        return d;
    endfunction

    function automatic logic [CODE_W-1:0] set_digit(input logic [CODE_W-1:0]  c,
                                                    input logic [IDX_W-1:0]   i,
                                                    input logic [DIGIT_W-1:0] d);
        logic [CODE_W-1:0] r;
        r = c;
        for (int k = 0; k < CODE_LEN; k++)
            if (i == IDX_W'(k))
                r[(CODE_LEN-1-k)*DIGIT_W +: DIGIT_W] = d;
        return r;
    endfunction

    function automatic logic [7:0] seg_decimal(input logic [IDX_W-1:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign cur_digit   = get_digit(code, idx);
    assign fail_next   = fail_cnt + FAIL_W'(1);
    // The commit must include the digit being written this cycle
    assign shadow_next = set_digit(shadow, idx, x);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ENTRY;
            idx        <= '0;
            fail_cnt   <= '0;
            timer      <= '0;
            code       <= DEFAULT_CODE;
            door_open  <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            case (state)
                ENTRY: begin
                    if (enter) begin
                        if (x == cur_digit) begin
                            if (idx == LAST_IDX) begin
                                state     <= OPEN;
                                idx       <= '0;
                                fail_cnt  <= '0;
                                door_open <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            idx <= '0;
                            if (fail_next == FAIL_MAX) begin
                                state      <= LOCKOUT;
                                fail_cnt   <= '0;
                                timer      <= TMR_LOAD;
                                locked_out <= 1'b1;
                            end else begin
                                fail_cnt <= fail_next;
                            end
                        end
                    end
                end
                OPEN: begin
                    if (lock) begin
                        state     <= ENTRY;
                        idx       <= '0;
                        door_open <= 1'b0;
                    end else if (prog) begin
                        state <= PROGRAM;
                        idx   <= '0;
                    end
                end
                PROGRAM: begin
                    if (lock) begin
                        state     <= ENTRY;
                        idx       <= '0;
                        door_open <= 1'b0;
                    end else if (enter) begin
                        if (idx == LAST_IDX) begin
                            code      <= shadow_next;
                            state     <= ENTRY;
                            idx       <= '0;
                            door_open <= 1'b0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                LOCKOUT: begin
                    // Loaded with LOCKOUT_CYCLES-1 so the flag spans exactly LOCKOUT_CYCLES clocks
                    if (timer == '0) begin
                        state      <= ENTRY;
                        locked_out <= 1'b0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

    // Shadow holds pending digits only; every commit rewrites all digits first,
    // so stale contents after reset or abort never reach the code register.
    always_ff @(posedge clk) begin
        if (state == PROGRAM && enter && !lock)
            shadow <= shadow_next;
    end

    always_comb begin
        seven_segment_data = 8'hFF;
        case (state)
            ENTRY:   seven_segment_data = seg_decimal(idx);
            OPEN:    seven_segment_data = 8'hC1;
            PROGRAM: seven_segment_data = 8'h8C;
            LOCKOUT: seven_segment_data = 8'hC7;
            default: seven_segment_data = 8'hFF;
        endcase
    end

    assign seven_segment_enable = 4'b1110;

endmodule

// File: tb/tb_param_combination_lock.sv
module tb_param_combination_lock;

    localparam int M_ENTRY = 0;
    localparam int M_OPEN  = 1;
    localparam int M_PROG  = 2;
    localparam int M_LOCK  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] x;
    logic       enter;
    logic       lock;
    logic       prog;
    logic       door_open;
    logic       locked_out;
    logic [7:0] seven_segment_data;
    logic [3:0] seven_segment_enable;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic       door;
        logic       lo;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    param_combination_lock #(
        .DIGIT_W(4),
        .CODE_LEN(4),
        .DEFAULT_CODE({4'd2, 4'd3, 4'd4, 4'd6}),
        .MAX_FAILS(3),
        .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .enter(enter),
        .lock(lock),
        .prog(prog),
        .door_open(door_open),
        .locked_out(locked_out),
        .seven_segment_data(seven_segment_data),
        .seven_segment_enable(seven_segment_enable)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_seg(input int mode, input int ix);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        case (mode)
            M_OPEN:  return 8'hC1;
            M_PROG:  return 8'h8C;
            M_LOCK:  return 8'hC7;
            default: return tbl[ix];
        endcase
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        assert (door_open === e.door) else begin
            n_fail++;
            $error("FAIL %s door_open observed %0b expected %0b", e.tag, door_open, e.door);
        end
        n_checks++;
        assert (locked_out === e.lo) else begin
            n_fail++;
            $error("FAIL %s locked_out observed %0b expected %0b", e.tag, locked_out, e.lo);
        end
        n_checks++;
        assert (seven_segment_data === e.seg) else begin
            n_fail++;
            $error("FAIL %s seven_segment_data observed %h expected %h", e.tag, seven_segment_data, e.seg);
        end
        n_checks++;
        assert (seven_segment_enable === 4'b1110) else begin
            n_fail++;
            $error("FAIL %s seven_segment_enable observed %b expected 1110", e.tag, seven_segment_enable);
        end
    endtask

    // Drive one cycle of inputs, record the outputs expected after the edge, then check them
    task automatic step(input logic r, input logic en, input logic [3:0] xv,
                        input logic lk, input logic pg,
                        input int mode, input int ix, input string tag);
        exp_t e;
        reset = r; enter = en; x = xv; lock = lk; prog = pg;
        e.tag  = tag;
        e.door = (mode == M_OPEN || mode == M_PROG);
        e.lo   = (mode == M_LOCK);
        e.seg  = exp_seg(mode, ix);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic press(input logic [3:0] xv, input int mode, input int ix, input string tag);
        step(1'b0, 1'b1, xv, 1'b0, 1'b0, mode, ix, tag);
    endtask

    task automatic idle(input int mode, input int ix, input string tag);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mode, ix, tag);
    endtask

    // Correct code entered from idx 0: idx 1,2,3 then OPEN
    task automatic enter_good(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d, input string tag);
        press(a, M_ENTRY, 1, {tag, "_d0"});
        press(b, M_ENTRY, 2, {tag, "_d1"});
        press(c, M_ENTRY, 3, {tag, "_d2"});
        press(d, M_OPEN,  0, {tag, "_open"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enter = 1'b0; x = '0; lock = 1'b0; prog = 1'b0;
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, M_ENTRY, 0, "reset");
        step(1'b1, 1'b1, 4'd2, 1'b1, 1'b1, M_ENTRY, 0, "reset_hold");

        // Basic open and close
        enter_good(4'd2, 4'd3, 4'd4, 4'd6, "basic");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, M_ENTRY, 0, "basic_lock");

        // Idle cycles hold idx
        press(4'd2, M_ENTRY, 1, "hold_d0");
        idle(M_ENTRY, 1, "hold_idle1");
        idle(M_ENTRY, 1, "hold_idle2");
        press(4'd3, M_ENTRY, 2, "hold_d1");
        press(4'd4, M_ENTRY, 3, "hold_d2");
        press(4'd6, M_OPEN,  0, "hold_open");
        press(4'd9, M_OPEN,  0, "open_enter_ignored");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, M_ENTRY, 0, "hold_lock");

        // One wrong entry, then success clears the fail count
        press(4'd2, M_ENTRY, 1, "wrong_d0");
        press(4'd3, M_ENTRY, 2, "wrong_d1");
        press(4'd5, M_ENTRY, 0, "wrong_d2");
        enter_good(4'd2, 4'd3, 4'd4, 4'd6, "retry");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, M_ENTRY, 0, "retry_lock");

        // Three fails -> lockout for exactly 16 cycles, inputs ignored
        press(4'd7, M_ENTRY, 0, "lo_f1");
        press(4'd7, M_ENTRY, 0, "lo_f2");
        press(4'd7, M_LOCK,  0, "lo_f3");
        for (int i = 0; i < 15; i++) begin
            case (i)
                0: press(4'd2, M_LOCK, 0, "lo_in_d0");
                1: press(4'd3, M_LOCK, 0, "lo_in_d1");
                2: press(4'd4, M_LOCK, 0, "lo_in_d2");
                3: press(4'd6, M_LOCK, 0, "lo_in_d3");
                4: step(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, M_LOCK, 0, "lo_in_all");
                default: idle(M_LOCK, 0, "lo_wait");
            endcase
        end
        idle(M_ENTRY, 0, "lo_release");
        enter_good(4'd2, 4'd3, 4'd4, 4'd6, "after_lo");

        // Program new code 1111
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, M_PROG, 0, "prog_req");
        press(4'd1, M_PROG,  0, "prog_d0");
        press(4'd1, M_PROG,  0, "prog_d1");
        press(4'd1, M_PROG,  0, "prog_d2");
        press(4'd1, M_ENTRY, 0, "prog_commit");
        press(4'd2, M_ENTRY, 0, "old_code_rejected");
        enter_good(4'd1, 4'd1, 4'd1, 4'd1, "new_code");

        // Lock has priority over program in OPEN
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, M_ENTRY, 0, "lock_beats_prog");
        enter_good(4'd1, 4'd1, 4'd1, 4'd1, "reopen");

        // Abort programming on the last digit: lock beats enter, code unchanged
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, M_PROG, 0, "abort_req");
        press(4'd9, M_PROG, 0, "abort_d0");
        press(4'd9, M_PROG, 0, "abort_d1");
        press(4'd9, M_PROG, 0, "abort_d2");
        step(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, M_ENTRY, 0, "abort_lock");
        enter_good(4'd1, 4'd1, 4'd1, 4'd1, "abort_code_kept");

        // Reset restores default code from OPEN after a code change
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, M_ENTRY, 0, "reset_open");
        enter_good(4'd2, 4'd3, 4'd4, 4'd6, "default_back");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, M_ENTRY, 0, "default_back_lock");

        // Reset mid-lockout
        press(4'd8, M_ENTRY, 0, "rlo_f1");
        press(4'd8, M_ENTRY, 0, "rlo_f2");
        press(4'd8, M_LOCK,  0, "rlo_f3");
        idle(M_LOCK, 0, "rlo_wait1");
        idle(M_LOCK, 0, "rlo_wait2");
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, M_ENTRY, 0, "rlo_reset");
        enter_good(4'd2, 4'd3, 4'd4, 4'd6, "rlo_open");

        // Reset mid-programming discards shadow digits
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, M_PROG, 0, "rpg_req");
        press(4'd5, M_PROG, 0, "rpg_d0");
        press(4'd5, M_PROG, 0, "rpg_d1");
        step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, M_ENTRY, 0, "rpg_reset");
        enter_good(4'd2, 4'd3, 4'd4, 4'd6, "rpg_open");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
